labelled_egress: RTL and testbench

- Receiving end of a labelled-data link: the consumer of a (label, data) pair stream in which each data word's security level is carried alongside it.
- Buffers pairs in a small FIFO and releases them to a downstream port that has its own clearance level.
- Guarantees no data word leaves with a label above the receiver's clearance: such words are either scrubbed to zero or held back, depending on SCRUB.
- Sits at a domain boundary, downstream of the label-propagation pipeline stages.

---
 rtl/labelled_egress.sv | 116 +++++++++++
 tb/tb_labelled_egress.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/labelled_egress.sv
// labelled_egress
//   Receiving end of a labelled-data link. (label, data) pairs are buffered in
//   a small FIFO and released to a downstream port that has its own clearance.
//   A head word whose label exceeds the clearance is either released with its
//   data forced to zero (SCRUB=1) or held at the head (SCRUB=0).
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready upstream handshake; in_lbl/in_data is the incoming pair
//   out_clr        receiver clearance (0 = L, 1 = H)
//   out_valid/ready downstream handshake; out_lbl/out_data is the head pair
//   out_scrubbed   presented word has been scrubbed to zero
//   out_blocked    head is held because its label exceeds clearance
//   scrub_cnt      saturating count of scrub or block events
//   count          FIFO occupancy
module labelled_egress #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int SCRUB = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_lbl,
    input  logic [DW-1:0]                in_data,
    input  logic                         out_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_lbl,
    output logic [DW-1:0]                out_data,
    output logic                         out_scrubbed,
    output logic                         out_blocked,
    output logic [CW-1:0]                scrub_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic SCRUB_EN = (SCRUB != 0);

    // Saturating increment for the event counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Each entry is {lbl, data}; both halves are always written together.
    logic [DW:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           blocked_q;

    logic [DW:0]    head;
    logic           head_lbl;
    logic [DW-1:0]  head_data;
    logic           nonempty;
    logic           allowed;
    logic           push;
    logic           pop;
    logic           cnt_inc;

    always_comb begin
        head         = mem[rd_ptr];
        head_lbl     = head[DW];
        head_data    = head[DW-1:0];
        nonempty     = (count != '0);
        allowed      = !head_lbl || out_clr;

        in_ready     = (count < DEPTH_C);
        out_valid    = nonempty && (allowed || SCRUB_EN);
        out_lbl      = nonempty ? head_lbl : 1'b0;
        out_data     = (nonempty && allowed) ? head_data : '0;
        out_scrubbed = nonempty && !allowed && SCRUB_EN;
        out_blocked  = nonempty && !allowed && !SCRUB_EN;

        push         = in_valid && in_ready;
        pop          = out_valid && out_ready;

        // Held heads are counted once, on the cycle they first become blocked;
        // a blocked head cannot pop, so a continuous block is a single head.
        cnt_inc      = SCRUB_EN ? (pop && out_scrubbed) : (out_blocked && !blocked_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            scrub_cnt <= '0;
            blocked_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_lbl, in_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cnt_inc) begin
                scrub_cnt <= sat_inc(scrub_cnt);
            end
            blocked_q <= out_blocked;
        end
    end

endmodule

// File: tb/tb_labelled_egress.sv
// Bench for labelled_egress: instance a is SCRUB=1 with a 2-bit counter,
// instance b is SCRUB=0 with an 8-bit counter. Expected output words are
// queued at stimulus time and checked by per-instance monitors.
module tb_labelled_egress;

    typedef struct packed {
        logic       lbl;
        logic [7:0] data;
        logic       scr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_lbl, a_out_clr, a_out_valid, a_out_ready;
    logic       a_out_lbl, a_out_scrubbed, a_out_blocked;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_scrub_cnt;
    logic [2:0] a_count;

    logic       b_in_valid, b_in_ready, b_in_lbl, b_out_clr, b_out_valid, b_out_ready;
    logic       b_out_lbl, b_out_scrubbed, b_out_blocked;
    logic [7:0] b_in_data, b_out_data;
    logic [7:0] b_scrub_cnt;
    logic [2:0] b_count;

    labelled_egress #(.DW(8), .DEPTH(4), .CW(2), .SCRUB(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_lbl(a_in_lbl), .in_data(a_in_data), .out_clr(a_out_clr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_lbl(a_out_lbl),
        .out_data(a_out_data), .out_scrubbed(a_out_scrubbed),
        .out_blocked(a_out_blocked), .scrub_cnt(a_scrub_cnt), .count(a_count)
    );

    labelled_egress #(.DW(8), .DEPTH(4), .CW(8), .SCRUB(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lbl(b_in_lbl), .in_data(b_in_data), .out_clr(b_out_clr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lbl(b_out_lbl),
        .out_data(b_out_data), .out_scrubbed(b_out_scrubbed),
        .out_blocked(b_out_blocked), .scrub_cnt(b_scrub_cnt), .count(b_count)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t expq_a[$];
    exp_t expq_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic l, input logic [7:0] d, input logic q,
                          input logic [7:0] ed, input logic es);
        a_in_valid = 1'b1;
        a_in_lbl   = l;
        a_in_data  = d;
        if (q) expq_a.push_back('{lbl: l, data: ed, scr: es});
        step();
        a_in_valid = 1'b0;
    endtask

    // Monitors: compare every word that is actually transferred.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (expq_a.size() == 0) begin
                chk("a_unexpected_word", {23'd0, a_out_lbl, a_out_data}, 32'hFFFF);
            end else begin
                exp_t e;
                e = expq_a.pop_front();
                chk("a_out_lbl", 32'(a_out_lbl), 32'(e.lbl));
                chk("a_out_data", 32'(a_out_data), 32'(e.data));
                chk("a_out_scrubbed", 32'(a_out_scrubbed), 32'(e.scr));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (expq_b.size() == 0) begin
                chk("b_unexpected_word", {23'd0, b_out_lbl, b_out_data}, 32'hFFFF);
            end else begin
                exp_t e;
                e = expq_b.pop_front();
                chk("b_out_lbl", 32'(b_out_lbl), 32'(e.lbl));
                chk("b_out_data", 32'(b_out_data), 32'(e.data));
                chk("b_out_scrubbed", 32'(b_out_scrubbed), 32'(e.scr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_lbl = 0; a_in_data = 0; a_out_clr = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_lbl = 0; b_in_data = 0; b_out_clr = 0; b_out_ready = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(a_count), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_data", 32'(a_out_data), 0);
        chk("rst_out_lbl", 32'(a_out_lbl), 0);
        chk("rst_out_scrubbed", 32'(a_out_scrubbed), 0);
        chk("rst_out_blocked", 32'(a_out_blocked), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_scrub_cnt", 32'(a_scrub_cnt), 0);

        // Single L word, one-cycle latency
        a_out_clr = 0; a_out_ready = 1;
        push_a(0, 8'hA5, 1, 8'hA5, 0);
        chk("t1_out_valid", 32'(a_out_valid), 1);
        chk("t1_count_full", 32'(a_count), 1);
        step();
        chk("t1_count_drained", 32'(a_count), 0);

        // H word scrubbed, then L word passes in order
        push_a(1, 8'h3C, 1, 8'h00, 1);
        push_a(0, 8'h11, 1, 8'h11, 0);
        step();
        chk("t2_scrub_cnt", 32'(a_scrub_cnt), 1);
        chk("t2_count", 32'(a_count), 0);

        // Fill to DEPTH, fifth held upstream, then wrap
        a_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            push_a(0, 8'h10 + 8'(i), 1, 8'h10 + 8'(i), 0);
        end
        chk("t4_in_ready_full", 32'(a_in_ready), 0);
        chk("t4_count_full", 32'(a_count), 4);
        a_in_valid = 1; a_in_lbl = 0; a_in_data = 8'h14;
        expq_a.push_back('{lbl: 1'b0, data: 8'h14, scr: 1'b0});
        step();
        chk("t4_count_held", 32'(a_count), 4);
        a_out_ready = 1;
        step();
        a_out_ready = 0;
        chk("t4_in_ready_after_pop", 32'(a_in_ready), 1);
        chk("t4_count_after_pop", 32'(a_count), 3);
        step();
        a_in_valid = 0;
        chk("t4_count_refill", 32'(a_count), 4);
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("t4_count_drained", 32'(a_count), 0);

        // Reset with three words buffered
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) push_a(1, 8'hE0 + 8'(i), 0, 8'h00, 0);
        chk("t5_count_pre", 32'(a_count), 3);
        chk("t5_scrub_cnt_pre", 32'(a_scrub_cnt), 1);
        rst = 1;
        step();
        rst = 0;
        chk("t5_count", 32'(a_count), 0);
        chk("t5_out_valid", 32'(a_out_valid), 0);
        chk("t5_out_data", 32'(a_out_data), 0);
        chk("t5_scrub_cnt", 32'(a_scrub_cnt), 0);
        chk("t5_in_ready", 32'(a_in_ready), 1);

        // H word with H clearance passes unscrubbed
        a_out_clr = 1; a_out_ready = 1;
        push_a(1, 8'h5A, 1, 8'h5A, 0);
        step();
        chk("t7_scrub_cnt", 32'(a_scrub_cnt), 0);

        // Counter saturation: five scrubbed pops on a 2-bit counter
        a_out_clr = 0;
        for (int i = 0; i < 5; i++) push_a(1, 8'hC0 + 8'(i), 1, 8'h00, 1);
        step();
        chk("t6_scrub_cnt_sat", 32'(a_scrub_cnt), 3);
        chk("t6_count", 32'(a_count), 0);

        // SCRUB=0: H word is held until clearance rises
        b_out_clr = 0; b_out_ready = 1;
        b_in_valid = 1; b_in_lbl = 1; b_in_data = 8'h77;
        expq_b.push_back('{lbl: 1'b1, data: 8'h77, scr: 1'b0});
        step();
        b_in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_out_valid_held", 32'(b_out_valid), 0);
            chk("t3_out_blocked", 32'(b_out_blocked), 1);
            chk("t3_out_data_held", 32'(b_out_data), 0);
            step();
        end
        chk("t3_scrub_cnt", 32'(b_scrub_cnt), 1);
        b_out_clr = 1;
        #1;
        chk("t3_out_valid_released", 32'(b_out_valid), 1);
        chk("t3_out_blocked_released", 32'(b_out_blocked), 0);
        step();
        chk("t3_count", 32'(b_count), 0);
        chk("t3_scrub_cnt_final", 32'(b_scrub_cnt), 1);

        step();
        chk("a_queue_empty", 32'(expq_a.size()), 0);
        chk("b_queue_empty", 32'(expq_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
